ram_access_unit: RTL and testbench

//  Initiator side of the single-port word RAM interface (wr, wr_mask[3:0], word addr, 32b data, 1-cycle registered read).

---
 rtl/mem_pkg.sv | 43 ++++
 rtl/ram_access_unit.sv | 105 ++++++++++
 tb/tb_ram_access_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared load/store helpers for the RAM access unit: size encoding, byte-lane masks,
// store data replication and load alignment/extension.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2,
        MEM_RSVD = 2'd3
    } mem_size_e;

    function automatic logic [3:0] lane_mask(mem_size_e size, logic [1:0] off);
        case (size)
            MEM_BYTE: return 4'b0001 << off;
            MEM_HALF: return 4'b0011 << off;
            MEM_WORD: return 4'b1111;
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_replicate(mem_size_e size, logic [31:0] data);
        case (size)
            MEM_BYTE: return {4{data[7:0]}};
            MEM_HALF: return {2{data[15:0]}};
            default:  return data;
        endcase
    endfunction

    // The RAM returns the whole word; the addressed lane is shifted down to bit 0.
    function automatic logic [31:0] load_extend(mem_size_e size, logic is_unsigned,
                                                logic [1:0] off, logic [31:0] word);
        logic [31:0] w_shifted;
        w_shifted = word >> {off, 3'b000};
        case (size)
            MEM_BYTE: return is_unsigned ? {24'h0, w_shifted[7:0]}
                                         : {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_HALF: return is_unsigned ? {16'h0, w_shifted[15:0]}
                                         : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default:  return word;
        endcase
    endfunction

endpackage

// File: rtl/ram_access_unit.sv
// Byte-addressed load/store front end for a single-port word RAM with a one-cycle
// registered read; each access runs IDLE -> DATA -> RESP and returns one buffered response.
module ram_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 ram_wr,
    output logic [3:0]           ram_wr_mask,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      r_state;
    mem_size_e   r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic        r_err;
    logic        r_wr;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    mem_size_e   w_size;
    logic        w_err;
    logic        w_out_of_range;
    logic        w_misaligned;
    logic        w_accept;

    assign w_size         = mem_size_e'(req_size);
    assign w_out_of_range = (req_addr[31:ADDR_BITS+2] != '0);
    assign w_misaligned   = ((w_size == MEM_HALF) && req_addr[0]) ||
                            ((w_size == MEM_WORD) && (req_addr[1:0] != 2'b00));
    assign w_err          = (w_size == MEM_RSVD) || w_misaligned || w_out_of_range;

    assign req_ready = (r_state == S_IDLE) && rst_n;
    assign w_accept  = req_valid && req_ready;

    // The RAM samples address/write on the accept edge, so these are driven straight from the request.
    assign ram_addr    = req_addr[ADDR_BITS+1:2];
    assign ram_wr      = w_accept && req_wr && !w_err;
    assign ram_wr_mask = w_err ? 4'b0000 : lane_mask(w_size, req_addr[1:0]);
    assign ram_wdata   = store_replicate(w_size, req_wdata);

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_DATA;
                        r_size     <= w_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= req_addr[1:0];
                        r_err      <= w_err;
                        r_wr       <= req_wr;
                    end
                end
                S_DATA: begin
                    r_rsp_rdata <= (!r_wr && !r_err) ? load_extend(r_size, r_unsigned, r_off, ram_rdata)
                                                     : 32'h0;
                    r_rsp_err   <= r_err;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_unit.sv
// Bench for ram_access_unit: a word RAM model serves the DUT while a byte-array
// reference memory predicts masks, store lanes and load results.
module tb_ram_access_unit;

    localparam int ADDR_BITS = 10;
    localparam int WORDS     = 1 << ADDR_BITS;
    localparam int BYTES     = 4 * WORDS;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_wr;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 ram_wr;
    logic [3:0]           ram_wr_mask;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [31:0]          ram_wdata;
    logic [31:0]          ram_rdata;

    ram_access_unit #(.ADDR_BITS(ADDR_BITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .ram_wr      (ram_wr),
        .ram_wr_mask (ram_wr_mask),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    // Word RAM with byte write enables and a registered read.
    logic [31:0] tb_ram [0:WORDS-1];
    logic        tb_clear = 1'b1;

    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < WORDS; i++) tb_ram[i] <= 32'h0;
        end else if (ram_wr) begin
            for (int i = 0; i < 4; i++)
                if (ram_wr_mask[i]) tb_ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
        ram_rdata <= tb_ram[ram_addr];
    end

    // Reference memory as a flat byte array.
    logic [7:0]  gmem [0:BYTES-1];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] last_rd;
    logic        last_err;

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the handshake.
    task automatic do_access(input bit wr, input logic [1:0] sz, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wdata, input int stall);
        bit          err;
        int          n;
        logic [3:0]  emask;
        logic [31:0] ewd;
        logic [31:0] erd;
        n     = (sz == 2'd3) ? 0 : (1 << sz);
        err   = (sz == 2'd3) || (addr >= 32'(BYTES)) || ((addr % n) != 0);
        emask = err ? 4'b0000 : 4'(((1 << n) - 1) << (addr % 4));
        ewd   = 32'h0;
        if (n > 0)
            for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wdata[8*(i % n) +: 8];
        erd = 32'h0;
        if (!wr && !err) begin
            for (int k = 0; k < n; k++) erd |= 32'(gmem[addr + k]) << (8 * k);
            if (!uns && n < 4 && erd[8*n-1]) erd |= ~((32'h1 << (8 * n)) - 1);
        end

        req_valid = 1'b1; req_wr = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        chk("ram_addr", 32'(ram_addr), (addr / 4) % WORDS);
        chk("ram_wr", 32'(ram_wr), 32'(wr && !err));
        chk("ram_wr_mask", 32'(ram_wr_mask), 32'(emask));
        if (wr && !err) chk("ram_wdata", ram_wdata, ewd);

        @(posedge clk);
        if (wr && !err)
            for (int k = 0; k < n; k++) gmem[addr + k] = wdata[8*k +: 8];
        #1 req_valid = 1'b0;

        @(negedge clk);
        chk("rsp_valid_lat1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rsp_valid_lat2", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", rsp_rdata, erd);
        chk("rsp_err", 32'(rsp_err), 32'(err));
        last_rd  = rsp_rdata;
        last_err = rsp_err;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rdata", rsp_rdata, erd);
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_ram_wr", 32'(ram_wr), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("ready_after_hs", 32'(req_ready), 32'd1);
        chk("valid_after_hs", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int          bad;
        logic [31:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < BYTES; i++) gmem[i] = 8'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;

        @(posedge clk); #1 tb_clear = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1 chk("ready_after_reset", 32'(req_ready), 32'd1);

        do_access(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
        do_access(0, 2'd2, 0, 32'h10, 32'h0, 0);
        chk("spec_word_load", last_rd, 32'hDEADBEEF);
        do_access(1, 2'd0, 0, 32'h13, 32'h00000080, 0);
        do_access(0, 2'd0, 0, 32'h13, 32'h0, 0);
        chk("spec_byte_signed", last_rd, 32'hFFFFFF80);
        do_access(0, 2'd0, 1, 32'h13, 32'h0, 0);
        chk("spec_byte_unsigned", last_rd, 32'h00000080);
        do_access(1, 2'd2, 0, 32'h20, 32'hAAAAAAAA, 0);
        do_access(1, 2'd1, 0, 32'h22, 32'h00001234, 0);
        do_access(0, 2'd2, 0, 32'h20, 32'h0, 0);
        chk("spec_half_merge", last_rd, 32'h1234AAAA);
        do_access(0, 2'd1, 0, 32'h22, 32'h0, 0);
        chk("spec_half_signed", last_rd, 32'h00001234);

        do_access(0, 2'd1, 0, 32'h01, 32'h0, 0);
        chk("err_half_misaligned", 32'(last_err), 32'd1);
        do_access(1, 2'd2, 0, 32'h06, 32'h55555555, 0);
        chk("err_word_misaligned", 32'(last_err), 32'd1);
        do_access(1, 2'd3, 0, 32'h10, 32'h77777777, 0);
        chk("err_reserved_size", 32'(last_err), 32'd1);
        do_access(0, 2'd2, 0, 32'h1000, 32'h0, 0);
        chk("err_out_of_range", 32'(last_err), 32'd1);

        do_access(0, 2'd2, 0, 32'h10, 32'h0, 5);

        // Reset while the load sits in DATA; a store request is held during reset.
        req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0; req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        @(negedge clk);
        chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_rdata", rsp_rdata, 32'h0);
        chk("rst_mid_ram_wr", 32'(ram_wr), 32'd0);
        req_valid = 1'b0; rst_n = 1'b1;
        #1 chk("rst_release_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_response", 32'(rsp_valid), 32'd0);
        end

        for (int it = 0; it < 150; it++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 4) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 1);
            if ($urandom_range(0, 19) == 0) a = a + 32'(BYTES) * 32'($urandom_range(1, 1000));
            do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                      $urandom_range(0, 3));
        end

        bad = 0;
        for (int w = 0; w < WORDS; w++)
            if (tb_ram[w] !== {gmem[4*w+3], gmem[4*w+2], gmem[4*w+1], gmem[4*w]}) bad++;
        chk("final_memory_mismatches", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
